// File: rtl/free_list.sv
// Circular free list of physical register indices for the rename stage.
// Dispatch pops from the head, commit pushes to the tail, and a mispredict rewinds the head.
module free_list #(
    parameter int ROB_DEPTH = 32,
    parameter int NUM_PREGS = ROB_DEPTH + 32,
    parameter int PW        = $clog2(NUM_PREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          deq_req,
    output logic          deq_valid,
    output logic [PW-1:0] deq_p_addr,
    input  logic          enq_valid,
    input  logic [PW-1:0] enq_p_addr,
    output logic [PW:0]   chkpt_head,
    input  logic          flush,
    input  logic [PW:0]   flush_head,
    output logic          empty,
    output logic          full,
    output logic          ovf_err
);

    logic [PW-1:0] mem_q [NUM_PREGS];
    logic [PW:0]   head_q, head_d;
    logic [PW:0]   tail_q, tail_d;
    logic          ovf_q, ovf_d;
    logic          deq_fire;
    logic          enq_fire;

    // Pointers carry one extra wrap bit: equal pointers mean empty, and equal
    // low bits with differing wrap bits mean full.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[PW] != tail_q[PW]) && (head_q[PW-1:0] == tail_q[PW-1:0]);

    // Handshake: a pop completes on a rising edge where deq_req and deq_valid
    // are both high and flush is low; deq_p_addr is presented first-word-fall-
    // through. A push completes where enq_valid is high, the index is nonzero
    // and the list is not full; there is no ready, so a push while full is lost
    // and flagged.
    assign deq_fire = deq_req && !empty && !flush;
    assign enq_fire = enq_valid && (enq_p_addr != '0) && !full;

    assign deq_valid  = !empty;
    assign deq_p_addr = mem_q[head_q[PW-1:0]];
    assign chkpt_head = head_q;
    assign ovf_err    = ovf_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ovf_d  = ovf_q;
        if (flush) begin
            head_d = flush_head;
        end else if (deq_fire) begin
            head_d = head_q + 1'b1;
        end
        if (enq_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (enq_valid && full) begin
            ovf_d = 1'b1;
        end
    end

    // Reset image: entry i holds i+1, the last entry wraps to 0 and sits just
    // past the tail, so p0 is never handed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem_q[i] <= PW'(i + 1);
            end
            head_q <= '0;
            tail_q <= (PW+1)'(NUM_PREGS - 1);
            ovf_q  <= 1'b0;
        end else begin
            if (enq_fire) begin
                mem_q[tail_q[PW-1:0]] <= enq_p_addr;
            end
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list with ROB_DEPTH=32 (64 physical registers).
module tb_free_list;

    localparam int PW = 6;

    logic          clk;
    logic          rst_n;
    logic          deq_req;
    logic          deq_valid;
    logic [PW-1:0] deq_p_addr;
    logic          enq_valid;
    logic [PW-1:0] enq_p_addr;
    logic [PW:0]   chkpt_head;
    logic          flush;
    logic [PW:0]   flush_head;
    logic          empty;
    logic          full;
    logic          ovf_err;

    int total;
    int bad;

    free_list #(.ROB_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .deq_req(deq_req), .deq_valid(deq_valid), .deq_p_addr(deq_p_addr),
        .enq_valid(enq_valid), .enq_p_addr(enq_p_addr),
        .chkpt_head(chkpt_head), .flush(flush), .flush_head(flush_head),
        .empty(empty), .full(full), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge: apply inputs for one rising edge, then idle them.
    task automatic drive(input logic dq, input logic ev, input logic [PW-1:0] ea,
                         input logic fl, input logic [PW:0] fh);
        deq_req    = dq;
        enq_valid  = ev;
        enq_p_addr = ea;
        flush      = fl;
        flush_head = fh;
        @(negedge clk);
        deq_req    = 1'b0;
        enq_valid  = 1'b0;
        enq_p_addr = '0;
        flush      = 1'b0;
        flush_head = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL reset_deq_valid got=%b exp=1", deq_valid); end
        total++; if (deq_p_addr !== 6'd1) begin bad++; $display("FAIL reset_deq_p_addr got=%0d exp=1", deq_p_addr); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%b exp=0", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (chkpt_head !== 7'd0) begin bad++; $display("FAIL reset_chkpt got=%0d exp=0", chkpt_head); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (deq_p_addr !== 6'd1) begin bad++; $display("FAIL release_deq_p_addr got=%0d exp=1", deq_p_addr); end
    endtask

    task automatic test_deq4();
        for (int i = 0; i < 4; i++) begin
            total++; if (deq_p_addr !== 6'(i + 1)) begin bad++; $display("FAIL deq4_addr i=%0d got=%0d exp=%0d", i, deq_p_addr, i + 1); end
            drive(1'b1, 1'b0, '0, 1'b0, '0);
        end
        total++; if (chkpt_head !== 7'd4) begin bad++; $display("FAIL deq4_chkpt got=%0d exp=4", chkpt_head); end
        total++; if (deq_p_addr !== 6'd5) begin bad++; $display("FAIL deq4_next got=%0d exp=5", deq_p_addr); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 59; i++) begin
            total++; if (deq_p_addr !== 6'(i + 5)) begin bad++; $display("FAIL drain_addr i=%0d got=%0d exp=%0d", i, deq_p_addr, i + 5); end
            drive(1'b1, 1'b0, '0, 1'b0, '0);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL drain_deq_valid got=%b exp=0", deq_valid); end
        total++; if (chkpt_head !== 7'd63) begin bad++; $display("FAIL drain_chkpt got=%0d exp=63", chkpt_head); end
        repeat (3) drive(1'b1, 1'b0, '0, 1'b0, '0);
        total++; if (chkpt_head !== 7'd63) begin bad++; $display("FAIL empty_pop_head got=%0d exp=63", chkpt_head); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_pop_empty got=%b exp=1", empty); end
        // push and pop together while empty: only the push takes effect
        drive(1'b1, 1'b1, 6'd17, 1'b0, '0);
        total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL nobypass_valid got=%b exp=1", deq_valid); end
        total++; if (deq_p_addr !== 6'd17) begin bad++; $display("FAIL nobypass_addr got=%0d exp=17", deq_p_addr); end
        total++; if (chkpt_head !== 7'd63) begin bad++; $display("FAIL nobypass_head got=%0d exp=63", chkpt_head); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 6'(20 + i), 1'b0, '0);
        total++; if (deq_p_addr !== 6'd17) begin bad++; $display("FAIL simul_pre got=%0d exp=17", deq_p_addr); end
        drive(1'b1, 1'b1, 6'd40, 1'b0, '0);
        for (int i = 0; i < 9; i++) begin
            total++; if (deq_p_addr !== 6'(20 + i)) begin bad++; $display("FAIL simul_old i=%0d got=%0d exp=%0d", i, deq_p_addr, 20 + i); end
            drive(1'b1, 1'b0, '0, 1'b0, '0);
        end
        total++; if (deq_p_addr !== 6'd40) begin bad++; $display("FAIL simul_new got=%0d exp=40", deq_p_addr); end
        total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%b exp=1", deq_valid); end
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_empty got=%b exp=1", empty); end
        total++; if (chkpt_head !== 7'd74) begin bad++; $display("FAIL simul_head got=%0d exp=74", chkpt_head); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (5) drive(1'b1, 1'b0, '0, 1'b0, '0);
        total++; if (chkpt_head !== 7'd5) begin bad++; $display("FAIL flush_chkpt got=%0d exp=5", chkpt_head); end
        for (int i = 0; i < 3; i++) begin
            total++; if (deq_p_addr !== 6'(6 + i)) begin bad++; $display("FAIL flush_spec i=%0d got=%0d exp=%0d", i, deq_p_addr, 6 + i); end
            drive(1'b1, 1'b0, '0, 1'b0, '0);
        end
        total++; if (chkpt_head !== 7'd8) begin bad++; $display("FAIL flush_pre_head got=%0d exp=8", chkpt_head); end
        // flush with a competing pop and a push of 50 in the same cycle
        drive(1'b1, 1'b1, 6'd50, 1'b1, 7'd5);
        total++; if (chkpt_head !== 7'd5) begin bad++; $display("FAIL flush_head got=%0d exp=5", chkpt_head); end
        total++; if (deq_p_addr !== 6'd6) begin bad++; $display("FAIL flush_addr got=%0d exp=6", deq_p_addr); end
    endtask

    task automatic test_overflow();
        logic [PW-1:0] e;
        // count is 59 here: a dropped p0 then exactly five pushes must fill it
        drive(1'b0, 1'b1, 6'd0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_notfull i=%0d got=%b exp=0", i, full); end
            drive(1'b0, 1'b1, 6'(33 + i), 1'b0, '0);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b exp=0", ovf_err); end
        drive(1'b0, 1'b1, 6'd9, 1'b0, '0);
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
        for (int i = 0; i < 64; i++) begin
            if (i < 58)       e = 6'(6 + i);
            else if (i == 58) e = 6'd50;
            else              e = 6'(33 + i - 59);
            total++; if (deq_p_addr !== e || deq_valid !== 1'b1) begin
                bad++; $display("FAIL full_drain i=%0d got=%0d/%b exp=%0d/1", i, deq_p_addr, deq_valid, e);
            end
            drive(1'b1, 1'b0, '0, 1'b0, '0);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 6'(11 + i), 1'b0, '0);
        total++; if (deq_p_addr !== 6'd11) begin bad++; $display("FAIL burst_first got=%0d exp=11", deq_p_addr); end
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        deq_req = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (chkpt_head !== 7'd0) begin bad++; $display("FAIL async_chkpt got=%0d exp=0", chkpt_head); end
        total++; if (deq_p_addr !== 6'd1) begin bad++; $display("FAIL async_addr got=%0d exp=1", deq_p_addr); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL async_ovf got=%b exp=0", ovf_err); end
        total++; if (empty !== 1'b0 || full !== 1'b0 || deq_valid !== 1'b1) begin
            bad++; $display("FAIL async_flags got=e%b f%b v%b exp=e0 f0 v1", empty, full, deq_valid);
        end
        @(negedge clk);
        deq_req = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        total++; if (deq_p_addr !== 6'd1) begin bad++; $display("FAIL async_release got=%0d exp=1", deq_p_addr); end
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        total++; if (deq_p_addr !== 6'd2) begin bad++; $display("FAIL async_pop got=%0d exp=2", deq_p_addr); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        deq_req    = 1'b0;
        enq_valid  = 1'b0;
        enq_p_addr = '0;
        flush      = 1'b0;
        flush_head = '0;
        test_reset();
        test_deq4();
        test_drain();
        test_simul();
        test_flush();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register indices at the producer end of the rename path.
- Dispatch pops one index per cycle; that index becomes the new `rd` physical mapping written into the rename table.
- Commit pushes back the previous physical mapping of a retiring destination.
- A branch mispredict rewinds the read pointer to a head checkpoint taken when the branch was dispatched, returning speculatively allocated registers to the list.

Parameters:
- ROB_DEPTH, 32, reorder buffer depth.
- NUM_PREGS, ROB_DEPTH+32, number of physical registers. Must be a power of two; equals the FIFO depth.
- PW, $clog2(NUM_PREGS), physical register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- deq_req  in  1  dispatch requests one free register this cycle.
- deq_valid  out  1  list non-empty; deq_p_addr is valid.
- deq_p_addr  out  PW  index at head (first-word-fall-through).
- enq_valid  in  1  commit returns a register.
- enq_p_addr  in  PW  register being freed.
- chkpt_head  out  PW+1  current head pointer, snapshotted by dispatch with each branch.
- flush  in  1  mispredict recovery strobe.
- flush_head  in  PW+1  checkpointed head to restore.
- empty  out  1  count == 0.
- full  out  1  count == NUM_PREGS.
- ovf_err  out  1  sticky; set when an enqueue arrives while full.

Behaviour:
- Storage: NUM_PREGS entries of PW bits. Pointers head and tail are PW+1 bits; the MSB is the wrap bit. count = tail - head, modulo 2^(PW+1).
- Reset (rst_n low, asynchronous):
  - entry[i] = i+1 for i = 0..NUM_PREGS-2; entry[NUM_PREGS-1] = 0.
  - head = 0, tail = NUM_PREGS-1, giving count = NUM_PREGS-1. p0 is the reset mapping of every architectural register and is never in the list.
  - ovf_err = 0, deq_valid = 1, deq_p_addr = 1, empty = 0, full = 0, chkpt_head = 0.
- Reset mid-operation discards all state and returns to the reset image immediately.
- Dequeue:
  - Fires when deq_req & !empty & !flush; head increments on the next edge.
  - deq_p_addr = entry[head[PW-1:0]], combinational, zero-cycle latency.
  - deq_req while empty has no effect; dispatch must stall on !deq_valid.
- Enqueue:
  - Fires when enq_valid & enq_p_addr != 0 & !full. Writes entry[tail[PW-1:0]]; tail increments.
  - enq_p_addr == 0 is silently dropped, because p0 is shared and never freed.
  - enq_valid while full drops the write and sets ovf_err, which stays set until reset.
- Simultaneous enqueue and dequeue:
  - Both occur in the same cycle; count is unchanged.
  - When empty there is no bypass: the dequeue is not served, and the pushed entry becomes visible the next cycle.
- Flush:
  - On flush, head <= flush_head and any dequeue that cycle is suppressed.
  - An enqueue in the same cycle is still performed normally.
  - Entries between flush_head and the old head are not overwritten, since total allocation is bounded by NUM_PREGS, so they become free again.
- Wrap-around: pointer low bits index storage and the MSB toggles on wrap. full/empty are derived from pointer equality plus the MSB.
- All outputs other than deq_p_addr and ovf_err are combinational from registered state.

Test Plan:
- Reset release, deq_req held 4 cycles -> deq_p_addr 1,2,3,4 on successive cycles; count 63→59 (NUM_PREGS=64).
- Drain: 63 dequeues -> empty=1, deq_valid=0. Further deq_req leaves head unchanged. Then enq 17 -> the next cycle deq_p_addr=17, deq_valid=1.
- Same-cycle enq 40 and deq at count 10 -> count stays 10; 40 emerges after the 9 older entries and one intervening pop.
- Checkpoint chkpt_head=5, then 3 dequeues (6,7,8), then flush with flush_head=5 and deq_req=1 in the same cycle -> no dequeue; next deq_p_addr=6; count restored to its pre-dequeue value.
- Enqueue p0 -> dropped; count unchanged. Fill to full (64), enqueue 9 -> dropped; ovf_err=1 and remains 1 until rst_n low.
- Async reset asserted mid-burst between clock edges -> outputs return to the reset values without waiting for a clock edge.
